// File: rtl/match_pe_ext_pipeline.sv
// Extending match PE. Each job compares PE_WIDTH bytes of history against head
// window data per beat. A fully matching beat re-issues itself at +PE_WIDTH, up
// to MAX_BEATS beats. Finished jobs queue in a credit-protected output FIFO and
// leave through an o_valid/o_ready handshake.
module match_pe_ext_pipeline #(
    parameter int IDX_W     = 2,
    parameter int PE_WIDTH  = 16,
    parameter int NBPIPE    = 3,
    parameter int HIST_LOG2 = 15,
    parameter int HEAD_LOG2 = 9,
    parameter int MAX_BEATS = 4,
    parameter int MAX_LEN   = 64,
    parameter int OUT_DEPTH = 8,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = $clog2(MAX_LEN + 1),
    parameter int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic                  i_last,
    input  logic [ADDR_W-1:0]     i_head_addr,
    input  logic [ADDR_W-1:0]     i_history_addr,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_last,
    output logic [LEN_W-1:0]      o_match_len,
    output logic [BEAT_W-1:0]     o_beats,
    input  logic [ADDR_W-1:0]     i_write_addr,
    input  logic [PE_WIDTH*8-1:0] i_write_data,
    input  logic                  i_write_enable,
    input  logic                  i_write_history_enable
);

    localparam int STAGES = NBPIPE + 2;
    localparam int BLEN_W = $clog2(PE_WIDTH + 1);
    localparam int PTR_W  = $clog2(OUT_DEPTH);
    localparam int CRED_W = $clog2(OUT_DEPTH + 1);
    localparam int DW     = PE_WIDTH * 8;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              last;
        logic [ADDR_W-1:0] head;
        logic [ADDR_W-1:0] hist;
        logic [LEN_W-1:0]  lenAcc;
        logic [BEAT_W-1:0] beats;
    } beat_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              last;
        logic [LEN_W-1:0]  len;
        logic [BEAT_W-1:0] beats;
    } res_t;

    logic [7:0]          r_headMem [0:(1<<HEAD_LOG2)-1];
    logic [7:0]          r_histMem [0:(1<<HIST_LOG2)-1];
    logic [DW-1:0]       r_headPipe [0:NBPIPE];
    logic [DW-1:0]       r_histPipe [0:NBPIPE];
    logic [PE_WIDTH-1:0] r_unsafePipe [0:NBPIPE];
    logic [PE_WIDTH-1:0] r_cmpEq;
    logic [STAGES-1:0]   r_stgValid;
    beat_t               r_stgBeat [0:STAGES-1];
    logic [CRED_W-1:0]   r_credits;
    res_t                r_fifoMem [0:OUT_DEPTH-1];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [CRED_W-1:0]   r_count;
    logic                r_oValid;
    res_t                r_outRes;

    logic                w_cmpValid;
    beat_t               w_cmpBeat;
    logic                w_run;
    logic [BLEN_W-1:0]   w_beatLen;
    logic [LEN_W:0]      w_lenSum;
    logic [LEN_W-1:0]    w_len;
    logic [BEAT_W-1:0]   w_beatsNext;
    logic                w_extend;
    logic                w_retire;
    logic                w_iReady;
    logic                w_accept;
    logic                w_pop;
    logic                w_issueValid;
    beat_t               w_issueBeat;
    logic [PE_WIDTH-1:0] w_unsafe;
    logic [HEAD_LOG2-1:0] w_headOff;
    logic [HIST_LOG2-1:0] w_histOff;
    res_t                w_pushRes;
    logic [PTR_W-1:0]    w_nextRd;
    logic [CRED_W-1:0]   w_nextCount;
    res_t                w_headNext;
    logic                w_unused;

    assign w_cmpValid = r_stgValid[STAGES-1];
    assign w_cmpBeat  = r_stgBeat[STAGES-1];
    assign w_unused   = ^i_write_addr[ADDR_W-1:HIST_LOG2];

    // Leading-ones match length of the compare stage and the extend/retire decision.
    always_comb begin
        w_run     = 1'b1;
        w_beatLen = '0;
        for (int k = 0; k < PE_WIDTH; k++) begin
            w_run     = w_run & r_cmpEq[k];
            w_beatLen = w_beatLen + BLEN_W'(w_run);
        end
        w_lenSum    = {1'b0, w_cmpBeat.lenAcc} + (LEN_W+1)'(w_beatLen);
        w_len       = (w_lenSum > (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_lenSum[LEN_W-1:0];
        w_beatsNext = w_cmpBeat.beats + BEAT_W'(1);
        w_extend    = w_cmpValid && (w_beatLen == BLEN_W'(PE_WIDTH)) &&
                      (w_beatsNext < BEAT_W'(MAX_BEATS)) && (w_len < LEN_W'(MAX_LEN));
        w_retire    = w_cmpValid && !w_extend;
    end

    // Recirculating beats take the issue slot ahead of new jobs. Credits bound outstanding jobs.
    always_comb begin
        w_iReady     = !w_extend && (r_credits < CRED_W'(OUT_DEPTH)) && !rst;
        w_accept     = i_valid && w_iReady;
        w_pop        = r_oValid && o_ready;
        w_issueValid = w_extend || w_accept;
        w_issueBeat  = '{idx: i_idx, last: i_last, head: i_head_addr, hist: i_history_addr,
                         lenAcc: '0, beats: '0};
        if (w_extend) begin
            w_issueBeat = '{idx: w_cmpBeat.idx, last: w_cmpBeat.last,
                            head: w_cmpBeat.head + ADDR_W'(PE_WIDTH),
                            hist: w_cmpBeat.hist + ADDR_W'(PE_WIDTH),
                            lenAcc: w_len, beats: w_beatsNext};
        end
    end

    // Flag bytes whose read address is being written this cycle, because the read returns pre-write data.
    always_comb begin
        w_unsafe  = '0;
        w_headOff = '0;
        w_histOff = '0;
        for (int k = 0; k < PE_WIDTH; k++) begin
            w_headOff = w_issueBeat.head[HEAD_LOG2-1:0] + HEAD_LOG2'(k) - i_write_addr[HEAD_LOG2-1:0];
            w_histOff = w_issueBeat.hist[HIST_LOG2-1:0] + HIST_LOG2'(k) - i_write_addr[HIST_LOG2-1:0];
            if (i_write_enable && (w_headOff < HEAD_LOG2'(PE_WIDTH))) begin
                w_unsafe[k] = 1'b1;
            end
            if (i_write_enable && i_write_history_enable && (w_histOff < HIST_LOG2'(PE_WIDTH))) begin
                w_unsafe[k] = 1'b1;
            end
        end
    end

    // Window buffer writes: a PE_WIDTH-byte chunk with wrapping byte addresses.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PE_WIDTH; k++) begin
            if (i_write_enable) begin
                r_headMem[i_write_addr[HEAD_LOG2-1:0] + HEAD_LOG2'(k)] <= i_write_data[k*8 +: 8];
            end
            if (i_write_enable && i_write_history_enable) begin
                r_histMem[i_write_addr[HIST_LOG2-1:0] + HIST_LOG2'(k)] <= i_write_data[k*8 +: 8];
            end
        end
    end

    // Buffer read, NBPIPE delay registers, then the registered bytewise compare.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PE_WIDTH; k++) begin
            r_headPipe[0][k*8 +: 8] <= r_headMem[w_issueBeat.head[HEAD_LOG2-1:0] + HEAD_LOG2'(k)];
            r_histPipe[0][k*8 +: 8] <= r_histMem[w_issueBeat.hist[HIST_LOG2-1:0] + HIST_LOG2'(k)];
        end
        r_unsafePipe[0] <= w_unsafe;
        for (int s = 1; s <= NBPIPE; s++) begin
            r_headPipe[s]   <= r_headPipe[s-1];
            r_histPipe[s]   <= r_histPipe[s-1];
            r_unsafePipe[s] <= r_unsafePipe[s-1];
        end
        for (int k = 0; k < PE_WIDTH; k++) begin
            r_cmpEq[k] <= (r_histPipe[NBPIPE][k*8 +: 8] == r_headPipe[NBPIPE][k*8 +: 8]) &&
                          !r_unsafePipe[NBPIPE][k];
        end
    end

    // Beat metadata travels alongside the data so it lines up with the compare stage.
    always_ff @(posedge clk) begin
        r_stgBeat[0] <= w_issueBeat;
        for (int s = 1; s < STAGES; s++) begin
            r_stgBeat[s] <= r_stgBeat[s-1];
        end
    end

    // Beat valid bits; clearing them on reset silently drops in-flight jobs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stgValid <= '0;
        end else begin
            r_stgValid <= {r_stgValid[STAGES-2:0], w_issueValid};
        end
    end

    // Credit counter: one per accepted job until its result is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= '0;
        end else if (w_accept && !w_pop) begin
            r_credits <= r_credits + CRED_W'(1);
        end else if (!w_accept && w_pop) begin
            r_credits <= r_credits - CRED_W'(1);
        end
    end

    // Next FIFO head: a push into the slot becoming head is forwarded, never shown the same cycle.
    always_comb begin
        w_pushRes   = '{idx: w_cmpBeat.idx, last: w_cmpBeat.last, len: w_len, beats: w_beatsNext};
        w_nextRd    = w_pop ? r_rdPtr + PTR_W'(1) : r_rdPtr;
        w_nextCount = r_count + CRED_W'(w_retire) - CRED_W'(w_pop);
        w_headNext  = r_fifoMem[w_nextRd];
        if (w_retire && (w_nextRd == r_wrPtr)) begin
            w_headNext = w_pushRes;
        end
    end

    // FIFO storage; credits guarantee a push always finds room.
    always_ff @(posedge clk) begin
        if (w_retire) begin
            r_fifoMem[r_wrPtr] <= w_pushRes;
        end
    end

    // FIFO pointers and registered output stage; outputs hold stale values when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_oValid <= 1'b0;
            r_outRes <= '0;
        end else begin
            if (w_retire) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            r_rdPtr  <= w_nextRd;
            r_count  <= w_nextCount;
            r_oValid <= (w_nextCount != '0);
            if (w_nextCount != '0) begin
                r_outRes <= w_headNext;
            end
        end
    end

    assign i_ready     = w_iReady;
    assign o_valid     = r_oValid;
    assign o_idx       = r_outRes.idx;
    assign o_last      = r_outRes.last;
    assign o_match_len = r_outRes.len;
    assign o_beats     = r_outRes.beats;

endmodule

// File: tb/tb_match_pe_ext_pipeline.sv
// Directed testbench for match_pe_ext_pipeline: latency, extension, saturation,
// credit backpressure, recirculation priority and reset mid-job.
module tb_match_pe_ext_pipeline;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [1:0]   i_idx;
    logic         i_last;
    logic [31:0]  i_head_addr;
    logic [31:0]  i_history_addr;
    logic         o_valid;
    logic         o_ready;
    logic [1:0]   o_idx;
    logic         o_last;
    logic [6:0]   o_match_len;
    logic [2:0]   o_beats;
    logic [31:0]  i_write_addr;
    logic [127:0] i_write_data;
    logic         i_write_enable;
    logic         i_write_history_enable;

    int passCount  = 0;
    int checkCount = 0;

    match_pe_ext_pipeline dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_idx(i_idx), .i_last(i_last),
        .i_head_addr(i_head_addr), .i_history_addr(i_history_addr),
        .o_valid(o_valid), .o_ready(o_ready), .o_idx(o_idx), .o_last(o_last),
        .o_match_len(o_match_len), .o_beats(o_beats),
        .i_write_addr(i_write_addr), .i_write_data(i_write_data),
        .i_write_enable(i_write_enable), .i_write_history_enable(i_write_history_enable)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic writeChunk(input logic [31:0] addr, input logic [127:0] data, input logic hist);
        i_write_addr = addr; i_write_data = data;
        i_write_enable = 1'b1; i_write_history_enable = hist;
        @(negedge clk);
        i_write_enable = 1'b0; i_write_history_enable = 1'b0;
    endtask

    // Offer a job from a negedge until accepted; returns just after the accepting edge.
    task automatic sendJob(input logic [1:0] idx, input logic last, input logic [31:0] head,
                           input logic [31:0] hist, output bit ok);
        i_valid = 1'b1; i_idx = idx; i_last = last; i_head_addr = head; i_history_addr = hist;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            if (i_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    // Wait at negedges for o_valid, bounded; cycles counts negedges since the accept cycle.
    task automatic waitResult(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!o_valid && cycles < 100);
    endtask

    task automatic applyStimulus;
        logic [127:0] d;
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(16*c + k);
            writeChunk(32'h2000 + 32'(16*c), d, 1'b1);
        end
        for (int k = 0; k < 16; k++) d[k*8 +: 8] = (k < 5) ? 8'(k) : ~8'(k);
        writeChunk(32'h0, d, 1'b0);
        for (int k = 0; k < 16; k++) d[k*8 +: 8] = (k == 8) ? ~8'(8'h60 + k) : 8'(8'h60 + k);
        writeChunk(32'h60, d, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
        i_idx = '0; i_last = 1'b0; i_head_addr = '0; i_history_addr = '0;
        i_write_addr = '0; i_write_data = '0; i_write_enable = 1'b0; i_write_history_enable = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++; if (o_valid !== 1'b0) $display("[TB] FAIL rst_ovalid: got %b expected 0", o_valid); else passCount++;
        checkCount++; if (i_ready !== 1'b0) $display("[TB] FAIL rst_iready: got %b expected 0", i_ready); else passCount++;
        rst = 1'b0;
        #1;
        checkCount++; if (i_ready !== 1'b1) $display("[TB] FAIL post_rst_iready: got %b expected 1", i_ready); else passCount++;
        checkCount++; if (o_valid !== 1'b0) $display("[TB] FAIL post_rst_ovalid: got %b expected 0", o_valid); else passCount++;
        @(negedge clk);
    endtask

    task automatic test_single_beat;
        bit ok; int cyc;
        sendJob(2'd1, 1'b1, 32'h0, 32'h2000, ok);
        waitResult(cyc);
        checkCount++; if (cyc != 6) $display("[TB] FAIL t1_latency: got %0d expected 6", cyc); else passCount++;
        checkCount++;
        if ({o_idx, o_last, o_match_len, o_beats} !== {2'd1, 1'b1, 7'd5, 3'd1})
            $display("[TB] FAIL t1_result: got idx=%0d last=%b len=%0d beats=%0d expected 1 1 5 1", o_idx, o_last, o_match_len, o_beats);
        else passCount++;
        @(negedge clk);
    endtask

    task automatic test_extend;
        bit ok; int cyc;
        sendJob(2'd2, 1'b0, 32'h40, 32'h2040, ok);
        waitResult(cyc);
        checkCount++; if (cyc != 16) $display("[TB] FAIL t2_latency: got %0d expected 16", cyc); else passCount++;
        checkCount++;
        if ({o_idx, o_last, o_match_len, o_beats} !== {2'd2, 1'b0, 7'd40, 3'd3})
            $display("[TB] FAIL t2_result: got idx=%0d last=%b len=%0d beats=%0d expected 2 0 40 3", o_idx, o_last, o_match_len, o_beats);
        else passCount++;
        @(negedge clk);
    endtask

    task automatic test_saturate;
        bit ok; int cyc; int extra;
        sendJob(2'd3, 1'b0, 32'h80, 32'h2080, ok);
        waitResult(cyc);
        checkCount++; if (cyc != 21) $display("[TB] FAIL t3_latency: got %0d expected 21", cyc); else passCount++;
        checkCount++;
        if ({o_idx, o_last, o_match_len, o_beats} !== {2'd3, 1'b0, 7'd64, 3'd4})
            $display("[TB] FAIL t3_result: got idx=%0d last=%b len=%0d beats=%0d expected 3 0 64 4", o_idx, o_last, o_match_len, o_beats);
        else passCount++;
        extra = 0;
        repeat (15) begin @(negedge clk); if (o_valid) extra++; end
        checkCount++; if (extra != 0) $display("[TB] FAIL t3_no_fifth: got %0d extra results expected 0", extra); else passCount++;
    endtask

    task automatic test_backpressure;
        int accepted; int cyc;
        o_ready = 1'b0; accepted = 0;
        i_head_addr = 32'h0; i_history_addr = 32'h2001;
        for (int n = 0; n < 10; n++) begin
            i_valid = 1'b1; i_idx = 2'(accepted); i_last = (accepted == 7);
            #1;
            if (i_ready) accepted++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        #1;
        checkCount++; if (accepted != 8) $display("[TB] FAIL t4_accepted: got %0d expected 8", accepted); else passCount++;
        checkCount++; if (i_ready !== 1'b0) $display("[TB] FAIL t4_iready_full: got %b expected 0", i_ready); else passCount++;
        checkCount++;
        if ({o_valid, o_idx} !== {1'b1, 2'd0}) $display("[TB] FAIL t4_head: got valid=%b idx=%0d expected 1 0", o_valid, o_idx);
        else passCount++;
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        i_valid = 1'b1; i_idx = 2'd0; i_last = 1'b0;
        #1;
        checkCount++; if (i_ready !== 1'b1) $display("[TB] FAIL t4_iready_after_pop: got %b expected 1", i_ready); else passCount++;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            waitResult(cyc);
            checkCount++;
            if ({o_valid, o_idx, o_last, o_match_len, o_beats} !== {1'b1, 2'((n + 1) % 4), (n == 6), 7'd0, 3'd1})
                $display("[TB] FAIL t4_drain%0d: got valid=%b idx=%0d last=%b len=%0d beats=%0d expected 1 %0d %0d 0 1",
                         n, o_valid, o_idx, o_last, o_match_len, o_beats, (n + 1) % 4, (n == 6));
            else passCount++;
        end
        repeat (3) @(negedge clk);
        #1;
        checkCount++;
        if ({o_valid, i_ready} !== 2'b01) $display("[TB] FAIL t4_empty: got valid=%b ready=%b expected 0 1", o_valid, i_ready);
        else passCount++;
    endtask

    task automatic test_back_to_back;
        bit ok; int cyc; int extra;
        @(negedge clk);
        sendJob(2'd3, 1'b0, 32'h40, 32'h2040, ok);
        repeat (5) @(negedge clk);
        i_valid = 1'b1; i_idx = 2'd2; i_last = 1'b0; i_head_addr = 32'h0; i_history_addr = 32'h2000;
        #1;
        checkCount++; if (i_ready !== 1'b0) $display("[TB] FAIL t5_iready_extend: got %b expected 0", i_ready); else passCount++;
        @(negedge clk);
        #1;
        checkCount++; if (i_ready !== 1'b1) $display("[TB] FAIL t5_iready_next: got %b expected 1", i_ready); else passCount++;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        waitResult(cyc);
        checkCount++; if (cyc != 6) $display("[TB] FAIL t5_b_latency: got %0d expected 6", cyc); else passCount++;
        checkCount++;
        if ({o_idx, o_match_len, o_beats} !== {2'd2, 7'd5, 3'd1})
            $display("[TB] FAIL t5_first: got idx=%0d len=%0d beats=%0d expected 2 5 1", o_idx, o_match_len, o_beats);
        else passCount++;
        waitResult(cyc);
        checkCount++;
        if ({o_valid, o_idx, o_match_len, o_beats} !== {1'b1, 2'd3, 7'd40, 3'd3})
            $display("[TB] FAIL t5_second: got valid=%b idx=%0d len=%0d beats=%0d expected 1 3 40 3", o_valid, o_idx, o_match_len, o_beats);
        else passCount++;
        extra = 0;
        repeat (20) begin @(negedge clk); if (o_valid) extra++; end
        checkCount++; if (extra != 0) $display("[TB] FAIL t5_no_dup: got %0d extra results expected 0", extra); else passCount++;
    endtask

    task automatic test_reset_midjob;
        bit ok; int cyc; int stale;
        sendJob(2'd0, 1'b0, 32'h80, 32'h2080, ok);
        sendJob(2'd1, 1'b0, 32'h80, 32'h2080, ok);
        sendJob(2'd2, 1'b0, 32'h80, 32'h2080, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkCount++; if (i_ready !== 1'b0) $display("[TB] FAIL t6_iready_rst: got %b expected 0", i_ready); else passCount++;
        @(negedge clk);
        checkCount++; if (o_valid !== 1'b0) $display("[TB] FAIL t6_ovalid_rst: got %b expected 0", o_valid); else passCount++;
        rst = 1'b0;
        stale = 0;
        repeat (30) begin @(negedge clk); if (o_valid) stale++; end
        checkCount++; if (stale != 0) $display("[TB] FAIL t6_stale: got %0d results expected 0", stale); else passCount++;
        sendJob(2'd1, 1'b1, 32'h0, 32'h2000, ok);
        waitResult(cyc);
        checkCount++; if (cyc != 6) $display("[TB] FAIL t6_latency: got %0d expected 6", cyc); else passCount++;
        checkCount++;
        if ({o_idx, o_last, o_match_len, o_beats} !== {2'd1, 1'b1, 7'd5, 3'd1})
            $display("[TB] FAIL t6_result: got idx=%0d last=%b len=%0d beats=%0d expected 1 1 5 1", o_idx, o_last, o_match_len, o_beats);
        else passCount++;
    endtask

    initial begin
        test_reset;
        applyStimulus;
        test_single_beat;
        test_extend;
        test_saturate;
        test_backpressure;
        test_back_to_back;
        test_reset_midjob;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
